// File: rtl/block_loader.sv
`default_nettype none
// ============================================================================
// Module   : block_loader
// Purpose  : Byte-serial to word-parallel loader. Packs bytes big-endian into
//            DATA_WIDTH-bit words and writes each word into a memory_module
//            through its r_w/addr/din port. A message's final byte zero-pads
//            the rest of the block. The loader then raises block_done and
//            stalls the byte stream until the consumer acknowledges.
// Revision : 1.0 - initial release
// ============================================================================
module block_loader #(
  parameter int ADDR       = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  input  logic                  byte_last,
  output logic                  byte_ready,
  output logic                  mem_r_w,
  output logic [ADDR-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  block_done,
  output logic                  block_last,
  input  logic                  block_ack
);

  // Bytes per word and the width of the byte counter that walks them.
  localparam int c_bpw   = DATA_WIDTH / 8;
  localparam int c_cnt_w = (c_bpw > 1) ? $clog2(c_bpw) : 1;

  localparam logic [c_cnt_w-1:0] c_last_byte = c_cnt_w'(c_bpw - 1);
  localparam logic [ADDR-1:0]    c_last_idx  = '1;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_WRITE   = 2'd1,
    ST_PAD     = 2'd2,
    ST_FULL    = 2'd3
  } state_t;

  // mem_addr doubles as the word index and mem_din as the word assembly
  // register: both must present exactly those values outside write cycles,
  // so keeping a second copy would only add registers that always match.
  state_t             r_state;
  logic [c_cnt_w-1:0] r_byte_cnt;
  logic               r_last_seen;

  logic w_accept;
  logic w_word_end;

  // A byte is taken when the producer offers it and the loader is collecting.
  assign w_accept   = byte_valid & byte_ready;
  // The accepted byte closes the word when it fills the last lane or ends
  // the message (a short final word stays left-aligned with zero low bytes).
  assign w_word_end = (r_byte_cnt == c_last_byte) | byte_last;

  // Loader state machine; every output is a register updated alongside the
  // state so that it always matches the state entered on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_COLLECT;
      r_byte_cnt  <= '0;
      r_last_seen <= 1'b0;
      byte_ready  <= 1'b0;
      mem_r_w     <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      block_done  <= 1'b0;
      block_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          byte_ready <= 1'b1;
          mem_r_w    <= 1'b0;
          if (w_accept) begin
            // Byte k of a word lands k lanes down from the MSB lane.
            for (int j = 0; j < c_bpw; j++) begin
              if (r_byte_cnt == c_cnt_w'(j)) begin
                mem_din[DATA_WIDTH-1-8*j -: 8] <= byte_in;
              end
            end
            r_byte_cnt <= r_byte_cnt + c_cnt_w'(1);
            if (byte_last) begin
              r_last_seen <= 1'b1;
            end
            if (w_word_end) begin
              r_state    <= ST_WRITE;
              byte_ready <= 1'b0;
              mem_r_w    <= 1'b1;
            end
          end
        end

        ST_WRITE: begin
          // The write strobe is high during this cycle; choose what follows.
          r_byte_cnt <= '0;
          mem_din    <= '0;
          if (mem_addr == c_last_idx) begin
            r_state    <= ST_FULL;
            mem_r_w    <= 1'b0;
            block_done <= 1'b1;
            block_last <= r_last_seen;
          end else if (r_last_seen) begin
            // Strobe stays high: padding writes follow back to back.
            r_state  <= ST_PAD;
            mem_addr <= mem_addr + ADDR'(1);
          end else begin
            r_state    <= ST_COLLECT;
            mem_r_w    <= 1'b0;
            byte_ready <= 1'b1;
            mem_addr   <= mem_addr + ADDR'(1);
          end
        end

        ST_PAD: begin
          // mem_din is already zero; one padding word per cycle.
          if (mem_addr == c_last_idx) begin
            r_state    <= ST_FULL;
            mem_r_w    <= 1'b0;
            block_done <= 1'b1;
            block_last <= r_last_seen;
          end else begin
            mem_addr <= mem_addr + ADDR'(1);
          end
        end

        ST_FULL: begin
          // Hold the block until the consumer has read it.
          if (block_ack) begin
            r_state     <= ST_COLLECT;
            r_last_seen <= 1'b0;
            mem_addr    <= '0;
            block_done  <= 1'b0;
            block_last  <= 1'b0;
            byte_ready  <= 1'b1;
          end
        end

        default: begin
          r_state    <= ST_COLLECT;
          byte_ready <= 1'b1;
          mem_r_w    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_block_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_block_loader
// Purpose  : Self-checking bench for block_loader. Messages are byte queues;
//            the expected memory image of a block is computed directly from
//            the message bytes (big-endian words, zero fill after the end).
// Revision : 1.0 - initial release
// ============================================================================
module tb_block_loader;

  localparam int ADDR      = 4;
  localparam int DW        = 32;
  localparam int BPW       = DW / 8;
  localparam int WORDS     = 1 << ADDR;
  localparam int BLK_BYTES = WORDS * BPW;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      byte_in;
  logic            byte_valid;
  logic            byte_last;
  logic            byte_ready;
  logic            mem_r_w;
  logic [ADDR-1:0] mem_addr;
  logic [DW-1:0]   mem_din;
  logic            block_done;
  logic            block_last;
  logic            block_ack;

  block_loader #(.ADDR(ADDR), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .mem_r_w    (mem_r_w),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .block_done (block_done),
    .block_last (block_last),
    .block_ack  (block_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;
  bit stuck       = 1'b0;

  // Current message and the writes observed for the current block.
  logic [7:0]         msg[$];
  bit                 msg_has_last;
  logic [ADDR+DW-1:0] wq[$];
  int                 wc[$];
  int                 tail;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected contents of word k of the block starting at message byte base.
  function automatic logic [DW-1:0] exp_word(input int base, input int k);
    logic [DW-1:0] w;
    int idx;
    w = '0;
    for (int j = 0; j < BPW; j++) begin
      idx = base + k * BPW + j;
      if (idx < msg.size()) w[DW-1-8*j -: 8] = msg[idx];
    end
    return w;
  endfunction

  // Offer one byte and return at the falling edge after it was accepted.
  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    if (stuck) return;
    byte_in    = b;
    byte_valid = 1'b1;
    byte_last  = last;
    while (byte_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      vectors++;
      miscompares++;
      $error("FAIL accept_timeout observed=byte_ready_low required=accept");
      stuck      = 1'b1;
      byte_valid = 1'b0;
      byte_last  = 1'b0;
      return;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  task automatic send_range(input int base, input int count, input int maxgap);
    int g;
    for (int i = base; i < base + count; i++) begin
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      byte_valid = 1'b0;
      repeat (g) @(negedge clk);
      send_byte(msg[i], logic'(msg_has_last && (i == msg.size() - 1)));
    end
  endtask

  // Record every write until a full block of writes has been seen.
  task automatic collect_block();
    int n;
    n = 0;
    wq.delete();
    wc.delete();
    while (wq.size() < WORDS && n < 3000 && !stuck) begin
      @(negedge clk);
      n++;
      if (mem_r_w === 1'b1) begin
        wq.push_back({mem_addr, mem_din});
        wc.push_back(cyc);
      end
    end
    if (n >= 3000) begin
      vectors++;
      miscompares++;
      $error("FAIL collect_timeout observed=%0d writes required=%0d", wq.size(), WORDS);
      stuck = 1'b1;
    end
  endtask

  // Called at the falling edge of the final write cycle.
  task automatic check_block(input int base, input string tag);
    bit exp_last;
    exp_last = msg_has_last && (msg.size() <= base + BLK_BYTES);
    check({tag, "_nwrites"}, 64'(wq.size()), 64'(WORDS));
    for (int k = 0; k < WORDS && k < wq.size(); k++)
      check({tag, "_write"}, 64'(wq[k]), 64'({ADDR'(k), exp_word(base, k)}));
    check({tag, "_done_early"}, 64'(block_done), 64'(0));
    @(negedge clk);
    check({tag, "_full"}, 64'({block_done, block_last, byte_ready, mem_r_w}),
          64'({1'b1, exp_last, 1'b0, 1'b0}));
  endtask

  task automatic run_block(input int base, input int count, input int maxgap, input string tag);
    fork
      send_range(base, count, maxgap);
      collect_block();
    join
    check_block(base, tag);
  endtask

  task automatic do_ack(input string tag);
    block_ack = 1'b1;
    @(negedge clk);
    block_ack = 1'b0;
    check({tag, "_ack"}, 64'({byte_ready, block_done, block_last, mem_addr}),
          64'({1'b1, 1'b0, 1'b0, ADDR'(0)}));
  endtask

  task automatic random_msg(input int len, input bit has_last);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
    msg_has_last = has_last;
  endtask

  initial begin
    rst        = 1'b1;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    block_ack  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({byte_ready, mem_r_w, mem_addr, mem_din, block_done, block_last}), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Idle after reset release.
    for (int i = 0; i < 20; i++) begin
      check("idle", 64'({byte_ready, mem_r_w, mem_addr, block_done, block_last}),
            64'({1'b1, 1'b0, ADDR'(0), 1'b0, 1'b0}));
      @(negedge clk);
    end

    // Counting bytes, full block with byte_last on the final byte.
    msg.delete();
    for (int i = 0; i < BLK_BYTES; i++) msg.push_back(8'(i));
    msg_has_last = 1'b1;
    run_block(0, BLK_BYTES, 0, "seq");
    if (wc.size() == WORDS)
      check("seq_span", 64'(wc[WORDS-1] - wc[0]), 64'((WORDS - 1) * (BPW + 1)));
    do_ack("seq");

    // Short message: partial second word, then zero padding.
    msg.delete();
    for (int i = 0; i < 6; i++) msg.push_back(8'(8'hA1 + i));
    msg_has_last = 1'b1;
    run_block(0, 6, 0, "short");
    if (wc.size() == WORDS)
      check("pad_span", 64'(wc[WORDS-1] - wc[1]), 64'(WORDS - 2));
    do_ack("short");

    // Two-block message; stall with data offered while the block is full.
    tail = $urandom_range(BLK_BYTES, 1);
    random_msg(BLK_BYTES + tail, 1'b1);
    run_block(0, BLK_BYTES, 0, "long0");
    for (int i = 0; i < 10; i++) begin
      byte_in    = 8'h55;
      byte_valid = 1'b1;
      @(negedge clk);
      check("stall", 64'({byte_ready, block_done, mem_r_w}), 64'(3'b010));
    end
    byte_valid = 1'b0;
    do_ack("long0");
    run_block(BLK_BYTES, tail, 0, "long1");
    do_ack("long1");

    // Same first block again with random idle gaps between bytes.
    msg          = msg[0:BLK_BYTES-1];
    msg_has_last = 1'b0;
    run_block(0, BLK_BYTES, 3, "gaps");
    do_ack("gaps");

    // Random single-block messages of random length.
    for (int r = 0; r < 3; r++) begin
      random_msg(int'($urandom_range(BLK_BYTES, 1)), 1'b1);
      run_block(0, msg.size(), 2, "rand");
      do_ack("rand");
    end

    // Acknowledge held high across a whole block releases FULL after one cycle.
    block_ack = 1'b1;
    random_msg(int'($urandom_range(BLK_BYTES, 1)), 1'b1);
    run_block(0, msg.size(), 1, "held_ack");
    @(negedge clk);
    check("held_ack_release", 64'({block_done, byte_ready}), 64'(2'b01));
    block_ack = 1'b0;
    @(negedge clk);

    // Reset in the middle of word 3, then a fresh word.
    random_msg(3 * BPW + 2, 1'b0);
    send_range(0, msg.size(), 0);
    check("partial_word", 64'({mem_addr, mem_din}), 64'({ADDR'(3), msg[12], msg[13], 16'h0000}));
    #1 rst = 1'b1;
    #1 check("mid_reset", 64'({byte_ready, mem_r_w, mem_addr, mem_din, block_done, block_last}), 64'(0));
    @(negedge clk);
    check("mid_reset_hold", 64'({byte_ready, mem_r_w, mem_addr, mem_din, block_done, block_last}), 64'(0));
    rst = 1'b0;
    msg.delete();
    msg.push_back(8'h11);
    msg.push_back(8'h22);
    msg.push_back(8'h33);
    msg.push_back(8'h44);
    msg_has_last = 1'b0;
    send_range(0, 4, 0);
    check("post_reset_write", 64'({mem_r_w, mem_addr, mem_din}), 64'({1'b1, ADDR'(0), 32'h11223344}));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
